// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO port controller: register offsets, register select
// enum and the address-offset decoder.
package gpio_ctrl_pkg;

  localparam int unsigned GPIO_PORT_W = 8;

  localparam logic [4:0] OFS_DIR  = 5'h00;
  localparam logic [4:0] OFS_OUT  = 5'h04;
  localparam logic [4:0] OFS_IN   = 5'h08;
  localparam logic [4:0] OFS_IEN  = 5'h0C;
  localparam logic [4:0] OFS_PEND = 5'h10;

  typedef enum logic [2:0] {
    RegNone,
    RegDir,
    RegOut,
    RegIn,
    RegIen,
    RegPend
  } gpio_reg_e;

  // Misaligned offsets fall through to RegNone because every register sits on a word.
  function automatic gpio_reg_e gpio_decode(input logic [4:0] ofs);
    gpio_reg_e sel;
    case (ofs)
      OFS_DIR:  sel = RegDir;
      OFS_OUT:  sel = RegOut;
      OFS_IN:   sel = RegIn;
      OFS_IEN:  sel = RegIen;
      OFS_PEND: sel = RegPend;
      default:  sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit debounce filter: the filtered value follows din only after din has differed
// from it for DEB_CYCLES consecutive clocks.
module gpio_debounce
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic filt,
  output logic filt_nxt
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            filt_q, filt_d;

  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (din != filt_q) begin
      if (cnt_q == CntW'(DEB_CYCLES - 1)) begin
        filt_d = din;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt     = filt_q;
  assign filt_nxt = filt_d;

endmodule

// File: rtl/gpio_port_ctrl.sv
// Memory-mapped GPIO port controller: register bank, input synchroniser, rising-edge IRQ.
// Optional per-pin input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_port_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH  = 32,
  parameter int unsigned          PORT_W     = GPIO_PORT_W,
  parameter logic [BIT_WIDTH-1:0] BASE_ADDR  = 32'h1001_0020,
  parameter int unsigned          DEB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] Address,
  input  logic [BIT_WIDTH-1:0] Data,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  output logic [BIT_WIDTH-1:0] ReadData,
  input  logic [PORT_W-1:0]    GPIO_PORT_IN,
  output logic [PORT_W-1:0]    GPIO_PORT_OUT,
  output logic [PORT_W-1:0]    GPIO_OE,
  output logic                 IRQ
);

  logic [BIT_WIDTH-1:0] ofs;
  gpio_reg_e            sel;
  logic [PORT_W-1:0]    wdata;
  logic [PORT_W-1:0]    rd_val;

  logic [PORT_W-1:0] dir_q, dir_d;
  logic [PORT_W-1:0] out_q, out_d;
  logic [PORT_W-1:0] ien_q, ien_d;
  logic [PORT_W-1:0] pend_q, pend_d;
  logic [PORT_W-1:0] s1_q, s2_q;
  logic [PORT_W-1:0] filt, filt_nxt, rise;

  logic unused_data;
  assign unused_data = ^Data[BIT_WIDTH-1:PORT_W];

  // Address decode
  assign ofs   = Address - BASE_ADDR;
  assign sel   = (ofs[BIT_WIDTH-1:5] == '0) ? gpio_decode(ofs[4:0]) : RegNone;
  assign wdata = Data[PORT_W-1:0];

  // Input synchroniser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= GPIO_PORT_IN;
      s2_q <= s1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < PORT_W; i++) begin : g_deb
    gpio_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .din     (s2_q[i]),
      .filt    (filt[i]),
      .filt_nxt(filt_nxt[i])
    );
  end
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES == 0);
  assign filt       = s2_q;
  assign filt_nxt   = s1_q;
`endif

  // Detect on the next filtered value so PEND sets on the same edge IN changes.
  assign rise = filt_nxt & ~filt;

  always_comb begin
    dir_d  = dir_q;
    out_d  = out_q;
    ien_d  = ien_q;
    pend_d = pend_q;
    if (MemWrite) begin
      case (sel)
        RegDir:  dir_d  = wdata;
        RegOut:  out_d  = wdata;
        RegIen:  ien_d  = wdata;
        RegPend: pend_d = pend_q & ~wdata;
        default: ;
      endcase
    end
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q  <= '0;
      out_q  <= '0;
      ien_q  <= '0;
      pend_q <= '0;
    end else begin
      dir_q  <= dir_d;
      out_q  <= out_d;
      ien_q  <= ien_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rd_val = '0;
    if (MemRead) begin
      case (sel)
        RegDir:  rd_val = dir_q;
        RegOut:  rd_val = out_q;
        RegIn:   rd_val = filt;
        RegIen:  rd_val = ien_q;
        RegPend: rd_val = pend_q;
        default: rd_val = '0;
      endcase
    end
  end

  assign ReadData      = {{(BIT_WIDTH - PORT_W){1'b0}}, rd_val};
  assign GPIO_PORT_OUT = out_q;
  assign GPIO_OE       = dir_q;
  assign IRQ           = |(pend_q & ien_q);

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed self-checking bench for gpio_port_ctrl: bus vector table plus hand-written
// sequences for reset, IRQ timing, W1C/set collision and debounce.
module tb_gpio_port_ctrl;

`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  localparam logic [31:0] A_DIR  = 32'h1001_0020;
  localparam logic [31:0] A_OUT  = 32'h1001_0024;
  localparam logic [31:0] A_IN   = 32'h1001_0028;
  localparam logic [31:0] A_IEN  = 32'h1001_002C;
  localparam logic [31:0] A_PEND = 32'h1001_0030;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Address, Data, ReadData;
  logic        MemWrite, MemRead;
  logic [7:0]  GPIO_PORT_IN, GPIO_PORT_OUT, GPIO_OE;
  logic        IRQ;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_port_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .Address      (Address),
    .Data         (Data),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .ReadData     (ReadData),
    .GPIO_PORT_IN (GPIO_PORT_IN),
    .GPIO_PORT_OUT(GPIO_PORT_OUT),
    .GPIO_OE      (GPIO_OE),
    .IRQ          (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(string name, logic we, logic re, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rd, logic [7:0] exp_out,
                              logic [7:0] exp_oe, logic exp_irq);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_out = exp_out; v.exp_oe = exp_oe; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] val);
    Address = addr;
    MemRead = 1'b1;
    #1;
    val     = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] val);
    Address  = addr;
    Data     = val;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    // pins stay 0xFF through the table; PEND cleared before it and IEN=0 so IRQ stays low
    vecs[0]  = mk("wr_out",      1, 0, A_OUT, 32'h0000_005A, 32'h0,  8'h5A, 8'h00, 0);
    vecs[1]  = mk("wr_dir",      1, 0, A_DIR, 32'h0000_00F0, 32'h0,  8'h5A, 8'hF0, 0);
    vecs[2]  = mk("rd_out",      0, 1, A_OUT, 32'h0,         32'h5A, 8'h5A, 8'hF0, 0);
    vecs[3]  = mk("rd_dir",      0, 1, A_DIR, 32'h0,         32'hF0, 8'h5A, 8'hF0, 0);
    vecs[4]  = mk("rdwr_out",    1, 1, A_OUT, 32'hFFFF_FF33, 32'h5A, 8'h33, 8'hF0, 0);
    vecs[5]  = mk("rd_out_new",  0, 1, A_OUT, 32'h0,         32'h33, 8'h33, 8'hF0, 0);
    vecs[6]  = mk("wr_misalign", 1, 0, 32'h1001_0025, 32'h77, 32'h0,  8'h33, 8'hF0, 0);
    vecs[7]  = mk("rd_misalign", 0, 1, 32'h1001_0025, 32'h0,  32'h0,  8'h33, 8'hF0, 0);
    vecs[8]  = mk("wr_past_map", 1, 0, 32'h1001_0034, 32'h77, 32'h0,  8'h33, 8'hF0, 0);
    vecs[9]  = mk("rd_past_map", 0, 1, 32'h1001_0034, 32'h0,  32'h0,  8'h33, 8'hF0, 0);
    vecs[10] = mk("wr_below",    1, 0, 32'h1001_001C, 32'h77, 32'h0,  8'h33, 8'hF0, 0);
    vecs[11] = mk("wr_in",       1, 0, A_IN,  32'h0,         32'h0,  8'h33, 8'hF0, 0);
    vecs[12] = mk("rd_in",       0, 1, A_IN,  32'h0,         32'hFF, 8'h33, 8'hF0, 0);
    vecs[13] = mk("wr_ien",      1, 0, A_IEN, 32'h0000_0101, 32'h0,  8'h33, 8'hF0, 0);
    vecs[14] = mk("rd_ien",      0, 1, A_IEN, 32'h0,         32'h01, 8'h33, 8'hF0, 0);

    rst = 1'b0; Address = '0; Data = '0; MemWrite = 1'b0; MemRead = 1'b0;
    GPIO_PORT_IN = 8'hFF;
    repeat (3) tick();
    check("rst_out", {24'h0, GPIO_PORT_OUT}, 32'h0);
    check("rst_oe",  {24'h0, GPIO_OE},       32'h0);
    check("rst_irq", {31'h0, IRQ},           32'h0);
    rd(A_IN, r);
    check("rst_rdata", r, 32'h0);

    rst = 1'b1;
    repeat (LAT - 1) tick();
    rd(A_IN, r);
    check("in_early", r, 32'h0);
    tick();
    rd(A_IN, r);
    check("in_after_rst", r, 32'hFF);
    rd(A_PEND, r);
    check("pend_first_sample", r, 32'hFF);
    check("irq_masked", {31'h0, IRQ}, 32'h0);
    wr(A_PEND, 32'hFF);
    rd(A_PEND, r);
    check("pend_cleared", r, 32'h0);

    foreach (vecs[i]) begin
      Address  = vecs[i].addr;
      Data     = vecs[i].wdata;
      MemWrite = vecs[i].we;
      MemRead  = vecs[i].re;
      #1;
      check({vecs[i].name, "_rdata"}, ReadData, vecs[i].exp_rd);
      tick();
      check({vecs[i].name, "_out"}, {24'h0, GPIO_PORT_OUT}, {24'h0, vecs[i].exp_out});
      check({vecs[i].name, "_oe"},  {24'h0, GPIO_OE},       {24'h0, vecs[i].exp_oe});
      check({vecs[i].name, "_irq"}, {31'h0, IRQ},           {31'h0, vecs[i].exp_irq});
    end
    MemWrite = 1'b0;
    MemRead  = 1'b0;

    // Rising edge on pin0 raises IRQ exactly LAT edges later
    GPIO_PORT_IN = 8'h00;
    repeat (LAT + 1) tick();
    rd(A_PEND, r);
    check("fall_no_pend", r, 32'h0);
    GPIO_PORT_IN = 8'h01;
    repeat (LAT - 1) tick();
    check("irq_before_edge", {31'h0, IRQ}, 32'h0);
    tick();
    check("irq_on_edge", {31'h0, IRQ}, 32'h1);
    rd(A_PEND, r);
    check("pend_bit0", r, 32'h01);
    rd(A_IN, r);
    check("in_bit0", r, 32'h01);
    wr(A_IEN, 32'h0);
    check("irq_ien_clr", {31'h0, IRQ}, 32'h0);
    rd(A_PEND, r);
    check("pend_kept", r, 32'h01);
    wr(A_IEN, 32'h1);
    check("irq_ien_set", {31'h0, IRQ}, 32'h1);
    wr(A_PEND, 32'h01);
    check("irq_w1c", {31'h0, IRQ}, 32'h0);
    rd(A_PEND, r);
    check("pend_w1c", r, 32'h0);

    // W1C landing on the same edge as a new rise: set wins
    GPIO_PORT_IN = 8'h00;
    repeat (LAT + 1) tick();
    GPIO_PORT_IN = 8'h01;
    repeat (LAT - 1) tick();
    check("collide_pre_irq", {31'h0, IRQ}, 32'h0);
    wr(A_PEND, 32'h01);
    check("collide_irq", {31'h0, IRQ}, 32'h1);
    rd(A_PEND, r);
    check("collide_pend", r, 32'h01);
    wr(A_PEND, 32'h01);
    check("collide_clr", {31'h0, IRQ}, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    GPIO_PORT_IN = 8'h03;
    repeat (3) tick();
    GPIO_PORT_IN = 8'h01;
    repeat (8) tick();
    rd(A_IN, r);
    check("deb_short_in", r, 32'h01);
    rd(A_PEND, r);
    check("deb_short_pend", r, 32'h0);
    GPIO_PORT_IN = 8'h03;
    repeat (6) tick();
    GPIO_PORT_IN = 8'h01;
    repeat (8) tick();
    rd(A_PEND, r);
    check("deb_long_pend", r, 32'h02);
`endif

    // Store in flight when reset asserts is discarded
    Address  = A_OUT;
    Data     = 32'hAA;
    MemWrite = 1'b1;
    #1 rst   = 1'b0;
    #1;
    check("rst_mid_out", {24'h0, GPIO_PORT_OUT}, 32'h0);
    tick();
    MemWrite = 1'b0;
    rst      = 1'b1;
    tick();
    check("rst_mid_out_after", {24'h0, GPIO_PORT_OUT}, 32'h0);
    check("rst_mid_oe_after",  {24'h0, GPIO_OE},       32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
